fifo_capture_ctrl: RTL and testbench
====================================

Name: fifo_capture_ctrl

Overview:
Sequencer that owns one sample FIFO in the phase-noise capture path. On a start command it flushes the FIFO and gates exactly N incoming ADC/phase samples into it. It then drains those N samples to a downstream valid/ready consumer and reports completion or error. It sits between the sample source, the FIFO and the readout/DMA stage, and is the only block that writes, pops or flushes that FIFO.

Parameters:
DATA_WIDTH, 32, sample width; must match the FIFO.
FIFO_SIZE, 1024, FIFO depth in entries; must match the FIFO.
SIZE_WIDTH, $clog2(FIFO_SIZE), base width for counters and level.

Ports:
clk  in  1  single clock
rstn  in  1  synchronous active-low reset
start  in  1  one-cycle capture request
abort  in  1  one-cycle abort request
num_samples  in  SIZE_WIDTH+1  capture length; latched on accepted start
smp_data  in  DATA_WIDTH  sample from source
smp_vld  in  1  sample valid
fifo_wr_data  out  DATA_WIDTH  FIFO push data (= smp_data)
fifo_wr_vld  out  1  FIFO push strobe
fifo_rd_data  in  DATA_WIDTH  FIFO head data, combinational from FIFO
fifo_not_empty  in  1  FIFO has data (FIFO out-ready)
fifo_pop  out  1  FIFO pop strobe
fifo_flush  out  1  FIFO synchronous flush
fifo_overflow  in  1  FIFO overflow event
fifo_underrun  in  1  FIFO underrun event
m_data  out  DATA_WIDTH  drained sample (= fifo_rd_data)
m_vld  out  1  drained sample valid
m_rdy  in  1  consumer ready
busy  out  1  state not IDLE/ERROR
done  out  1  one-cycle completion pulse
error  out  1  sticky error flag
err_code  out  2  01 bad length, 10 overflow, 11 underrun
cap_cnt  out  SIZE_WIDTH+1  samples pushed this run
drn_cnt  out  SIZE_WIDTH+1  samples popped this run

Behaviour:
- Reset (rstn=0 at posedge): state IDLE. All outputs 0: fifo_wr_vld, fifo_pop, fifo_flush, m_vld, busy, done, error, err_code, cap_cnt, drn_cnt. Latched length cleared. A reset mid-run abandons the run with no done pulse.
- State machine: IDLE, FLUSH, CAPTURE, DRAIN, DONE, ERROR. All transitions occur on the clock edge.
- IDLE, start=1:
  - num_samples=0 or num_samples>FIFO_SIZE -> ERROR, err_code=01.
  - Otherwise latch num_samples, clear cap_cnt, drn_cnt, error and err_code -> FLUSH.
- FLUSH: fifo_flush=1 for exactly one cycle -> CAPTURE. smp_vld is ignored during FLUSH.
- CAPTURE:
  - fifo_wr_vld = smp_vld & (cap_cnt < latched N); cap_cnt increments on each push.
  - The cycle after the push that makes cap_cnt==N -> DRAIN. Further smp_vld is dropped and never pushed.
- DRAIN:
  - m_vld = fifo_not_empty & (drn_cnt < N). m_data = fifo_rd_data (zero latency).
  - fifo_pop = m_vld & m_rdy; drn_cnt increments on each pop.
  - m_vld may drop between beats. m_data is stable while m_vld=1 and m_rdy=0, because the FIFO head does not move.
  - After the pop that makes drn_cnt==N -> DONE.
- DONE: done=1 for one cycle -> IDLE. cap_cnt and drn_cnt hold their final values until the next accepted start.
- Errors:
  - fifo_overflow=1 in CAPTURE or DRAIN -> ERROR, err_code=10.
  - fifo_underrun=1 in CAPTURE or DRAIN -> ERROR, err_code=11.
  - If both are set in the same cycle, overflow wins.
  - Entry to ERROR sets error=1 and asserts fifo_flush for one cycle. No push or pop occurs while in ERROR.
- ERROR: start is ignored. abort -> IDLE; error and err_code stay set until the next accepted start.
- Abort: in FLUSH, CAPTURE, DRAIN or DONE -> IDLE, with fifo_flush=1 for one cycle on the transition and no done pulse. abort in IDLE is a no-op.
- Simultaneous commands: start and abort in the same cycle -> abort wins. start while busy=1 is ignored.
- Counters are SIZE_WIDTH+1 bits and saturate at FIFO_SIZE; wrap is impossible by construction.
- busy=1 in FLUSH, CAPTURE, DRAIN and DONE.

Test Plan:
- N=4, smp_vld continuous with data 1..4, m_rdy=1: one fifo_flush cycle, 4 pushes, m_data 1,2,3,4 on consecutive cycles, done one cycle later, cap_cnt=drn_cnt=4.
- N=3 with 5 samples offered during CAPTURE: only the first 3 are pushed, the 4th and 5th are never seen on fifo_wr_vld, and drain outputs exactly 3 beats.
- DRAIN with m_rdy toggled 1,0,0,1,...: m_data is held steady while stalled, fifo_pop only fires on m_vld&m_rdy, and the output order is preserved.
- num_samples=0, then num_samples=FIFO_SIZE+1: ERROR with err_code=01, no fifo_flush, busy=0. abort -> IDLE. A following legal start clears error.
- Inject fifo_underrun=1 mid-DRAIN: next state ERROR, err_code=11, one fifo_flush pulse, fifo_pop=0 afterwards, start is ignored until abort.
- start and abort in the same cycle from IDLE: stays IDLE. abort mid-CAPTURE: one fifo_flush pulse, IDLE, no done. rstn=0 mid-DRAIN: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/fifo_capture_ctrl_if.sv
// rtl/fifo_capture_ctrl_if.sv - sample source, FIFO and drain-stream signals of the capture controller
interface fifo_capture_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] smp_data;
    logic                  smp_vld;
    logic [DATA_WIDTH-1:0] fifo_wr_data;
    logic                  fifo_wr_vld;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_not_empty;
    logic                  fifo_pop;
    logic                  fifo_flush;
    logic                  fifo_overflow;
    logic                  fifo_underrun;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_vld;
    logic                  m_rdy;

    modport master (
        input  smp_data, smp_vld, fifo_rd_data, fifo_not_empty,
               fifo_overflow, fifo_underrun, m_rdy,
        output fifo_wr_data, fifo_wr_vld, fifo_pop, fifo_flush, m_data, m_vld
    );

    modport slave (
        output smp_data, smp_vld, fifo_rd_data, fifo_not_empty,
               fifo_overflow, fifo_underrun, m_rdy,
        input  fifo_wr_data, fifo_wr_vld, fifo_pop, fifo_flush, m_data, m_vld
    );
endinterface

// File: rtl/fifo_capture_ctrl.sv
// rtl/fifo_capture_ctrl.sv - flushes, fills with N samples and drains one sample FIFO
module fifo_capture_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_SIZE  = 1024,
    parameter int SIZE_WIDTH = $clog2(FIFO_SIZE)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SIZE_WIDTH:0]   num_samples,
    fifo_capture_ctrl_if.master   bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [SIZE_WIDTH:0]   cap_cnt,
    output logic [SIZE_WIDTH:0]   drn_cnt
);
    localparam logic [SIZE_WIDTH:0] L_MAX = (SIZE_WIDTH+1)'(FIFO_SIZE);

    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_CAPTURE, S_DRAIN, S_DONE, S_ERROR
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [SIZE_WIDTH:0] r_len;
    logic [SIZE_WIDTH:0] r_cap;
    logic [SIZE_WIDTH:0] r_drn;
    logic                r_error;
    logic [1:0]          r_err_code;
    logic                r_flush;
    logic                w_len_bad;
    logic                w_start_ok;
    logic                w_push;
    logic                w_m_vld;
    logic                w_pop;
    logic                w_fault;

    always_comb begin
        w_len_bad  = (num_samples == '0) || (num_samples > L_MAX);
        w_start_ok = start && !abort;
        w_push     = (r_state == S_CAPTURE) && bus.smp_vld && (r_cap < r_len);
        w_m_vld    = (r_state == S_DRAIN) && bus.fifo_not_empty && (r_drn < r_len);
        w_pop      = w_m_vld && bus.m_rdy;
        w_fault    = bus.fifo_overflow || bus.fifo_underrun;

        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_start_ok) w_next = w_len_bad ? S_ERROR : S_FLUSH;
            S_FLUSH:   w_next = abort ? S_IDLE : S_CAPTURE;
            S_CAPTURE: begin
                if (abort)                               w_next = S_IDLE;
                else if (w_fault)                        w_next = S_ERROR;
                else if (w_push && (r_cap + 1'b1 == r_len)) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)                               w_next = S_IDLE;
                else if (w_fault)                        w_next = S_ERROR;
                else if (w_pop && (r_drn + 1'b1 == r_len))  w_next = S_DONE;
            end
            S_DONE:    w_next = S_IDLE;
            S_ERROR:   if (abort) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // r_flush is the one-cycle flush issued after an abort or a FIFO fault
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_cap      <= '0;
            r_drn      <= '0;
            r_error    <= 1'b0;
            r_err_code <= 2'b00;
            r_flush    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_flush <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        if (w_len_bad) begin
                            r_error    <= 1'b1;
                            r_err_code <= 2'b01;
                        end else begin
                            r_len      <= num_samples;
                            r_cap      <= '0;
                            r_drn      <= '0;
                            r_error    <= 1'b0;
                            r_err_code <= 2'b00;
                        end
                    end
                end
                S_FLUSH, S_DONE: if (abort) r_flush <= 1'b1;
                S_CAPTURE, S_DRAIN: begin
                    if (abort) begin
                        r_flush <= 1'b1;
                    end else if (w_fault) begin
                        r_flush    <= 1'b1;
                        r_error    <= 1'b1;
                        r_err_code <= bus.fifo_overflow ? 2'b10 : 2'b11;
                    end
                end
                default: ;
            endcase
            if (w_push) r_cap <= r_cap + 1'b1;
            if (w_pop)  r_drn <= r_drn + 1'b1;
        end
    end

    assign bus.fifo_wr_data = bus.smp_data;
    assign bus.fifo_wr_vld  = w_push;
    assign bus.fifo_pop     = w_pop;
    assign bus.fifo_flush   = (r_state == S_FLUSH) || r_flush;
    assign bus.m_data       = bus.fifo_rd_data;
    assign bus.m_vld        = w_m_vld;

    assign busy     = (r_state == S_FLUSH) || (r_state == S_CAPTURE) ||
                      (r_state == S_DRAIN) || (r_state == S_DONE);
    assign done     = (r_state == S_DONE) && !abort;
    assign error    = r_error;
    assign err_code = r_err_code;
    assign cap_cnt  = r_cap;
    assign drn_cnt  = r_drn;
endmodule

// File: tb/tb_fifo_capture_ctrl.sv
// tb/tb_fifo_capture_ctrl.sv - scoreboard bench for fifo_capture_ctrl with a behavioural FIFO
module tb_fifo_capture_ctrl;
    localparam int DW = 16;
    localparam int FS = 8;
    localparam int SW = $clog2(FS);

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          abort;
    logic [SW:0]   num_samples;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_code;
    logic [SW:0]   cap_cnt;
    logic [SW:0]   drn_cnt;

    fifo_capture_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    fifo_capture_ctrl #(.DATA_WIDTH(DW), .FIFO_SIZE(FS)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .num_samples(num_samples), .bus(bus), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .cap_cnt(cap_cnt), .drn_cnt(drn_cnt)
    );

    always #5 clk = ~clk;

    // behavioural sample FIFO, head combinational
    logic [DW-1:0] fmem [16];
    logic [3:0]    wp;
    logic [3:0]    rp;
    logic [4:0]    fcnt;
    logic          pop_eff;
    assign pop_eff           = bus.fifo_pop && (fcnt != 0);
    assign bus.fifo_rd_data  = fmem[rp];
    assign bus.fifo_not_empty = (fcnt != 0);

    always @(posedge clk) begin
        if (!rstn || bus.fifo_flush) begin
            wp <= '0; rp <= '0; fcnt <= '0;
        end else begin
            if (bus.fifo_wr_vld) begin
                fmem[wp] <= bus.fifo_wr_data;
                wp <= wp + 4'd1;
            end
            if (pop_eff) rp <= rp + 4'd1;
            fcnt <= fcnt + 5'(bus.fifo_wr_vld) - 5'(pop_eff);
        end
    end

    int checks = 0;
    int errors = 0;
    int flush_cnt = 0;
    int done_cnt = 0;
    int push_cnt = 0;
    int pop_cnt = 0;
    logic [DW-1:0] exp_q [$];

    // monitor: scoreboard on drained beats plus stall stability
    initial begin
        logic          hold_v;
        logic [DW-1:0] hold_d;
        logic [DW-1:0] e;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (bus.fifo_flush)  flush_cnt++;
            if (done)            done_cnt++;
            if (bus.fifo_wr_vld) push_cnt++;
            if (bus.fifo_pop)    pop_cnt++;
            if (bus.m_vld || bus.fifo_pop) begin
                checks++;
                if (bus.fifo_pop !== (bus.m_vld && bus.m_rdy)) begin
                    errors++;
                    $display("FAIL pop_strobe actual=%0b expected=%0b", bus.fifo_pop, bus.m_vld && bus.m_rdy);
                end
            end
            if (hold_v && bus.m_vld) begin
                checks++;
                if (bus.m_data !== hold_d) begin
                    errors++;
                    $display("FAIL stall_hold actual=%0d expected=%0d", bus.m_data, hold_d);
                end
            end
            if (bus.m_vld && bus.m_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL drain_extra actual=%0d expected=none", bus.m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.m_data !== e) begin
                        errors++;
                        $display("FAIL drain_data actual=%0d expected=%0d", bus.m_data, e);
                    end
                end
            end
            hold_v = bus.m_vld && !bus.m_rdy;
            hold_d = bus.m_data;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        num_samples = (SW+1)'(n);
        tick(1);
        start = 1'b0;
    endtask

    task automatic capture(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            bus.smp_vld  = 1'b1;
            bus.smp_data = DW'(base + i);
            exp_q.push_back(DW'(base + i));
            tick(1);
        end
        bus.smp_vld = 1'b0;
    endtask

    initial begin
        int f0, d0, p0, q0;
        logic rdy_pat [8];
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        rstn = 1'b0; start = 1'b0; abort = 1'b0; num_samples = '0;
        bus.smp_vld = 1'b0; bus.smp_data = '0; bus.m_rdy = 1'b0;
        bus.fifo_overflow = 1'b0; bus.fifo_underrun = 1'b0;
        tick(3);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_flags", int'({bus.fifo_wr_vld, bus.fifo_pop, bus.fifo_flush, bus.m_vld, done, error}), 0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_counts", int'({cap_cnt, drn_cnt}), 0);
        rstn = 1'b1;
        tick(1);

        // N=4, continuous samples and ready
        f0 = flush_cnt; d0 = done_cnt;
        bus.m_rdy = 1'b1;
        do_start(4);
        @(negedge clk);
        check("t1_flush", int'(bus.fifo_flush), 1);
        tick(1);
        capture(4, 1);
        p0 = pop_cnt;
        tick(4);
        @(negedge clk);
        check("t1_pops", pop_cnt - p0, 4);
        check("t1_done", int'(done), 1);
        tick(1);
        @(negedge clk);
        check("t1_idle", int'(busy), 0);
        check("t1_cap", int'(cap_cnt), 4);
        check("t1_drn", int'(drn_cnt), 4);
        check("t1_flushes", flush_cnt - f0, 1);
        check("t1_dones", done_cnt - d0, 1);
        check("t1_q_empty", exp_q.size(), 0);

        // N=3 with five samples offered
        q0 = push_cnt; p0 = pop_cnt; d0 = done_cnt;
        do_start(3);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            bus.smp_vld  = 1'b1;
            bus.smp_data = DW'(10 + i);
            if (i < 3) exp_q.push_back(DW'(10 + i));
            tick(1);
        end
        bus.smp_vld = 1'b0;
        tick(3);
        @(negedge clk);
        check("t2_pushes", push_cnt - q0, 3);
        check("t2_pops", pop_cnt - p0, 3);
        check("t2_dones", done_cnt - d0, 1);
        check("t2_cap", int'(cap_cnt), 3);
        check("t2_q_empty", exp_q.size(), 0);

        // stalled drain with ready pattern 1,0,0,1,0,1,0,1
        p0 = pop_cnt;
        bus.m_rdy = 1'b0;
        do_start(4);
        tick(1);
        capture(4, 20);
        for (int i = 0; i < 8; i++) begin
            bus.m_rdy = rdy_pat[i];
            tick(1);
        end
        bus.m_rdy = 1'b1;
        @(negedge clk);
        check("t3_done", int'(done), 1);
        check("t3_pops", pop_cnt - p0, 4);
        check("t3_drn", int'(drn_cnt), 4);
        tick(1);
        check("t3_q_empty", exp_q.size(), 0);

        // illegal lengths, sticky error, clear on legal start
        f0 = flush_cnt;
        do_start(0);
        @(negedge clk);
        check("t4_err0", int'(error), 1);
        check("t4_code0", int'(err_code), 1);
        check("t4_busy0", int'(busy), 0);
        abort = 1'b1; tick(1); abort = 1'b0;
        @(negedge clk);
        check("t4_sticky", int'(error), 1);
        tick(1);
        do_start(FS + 1);
        @(negedge clk);
        check("t4_code_big", int'(err_code), 1);
        check("t4_busy_big", int'(busy), 0);
        check("t4_no_flush", flush_cnt - f0, 0);
        abort = 1'b1; tick(1); abort = 1'b0;
        do_start(2);
        @(negedge clk);
        check("t4_err_clr", int'(error), 0);
        check("t4_code_clr", int'(err_code), 0);
        check("t4_busy_run", int'(busy), 1);
        tick(1);
        capture(2, 30);
        tick(4);
        check("t4_q_empty", exp_q.size(), 0);

        // underrun mid-drain
        bus.m_rdy = 1'b0;
        do_start(4);
        tick(1);
        capture(4, 40);
        bus.m_rdy = 1'b1;
        tick(1);
        f0 = flush_cnt;
        bus.m_rdy = 1'b0;
        bus.fifo_underrun = 1'b1;
        tick(1);
        bus.fifo_underrun = 1'b0;
        exp_q.delete();
        p0 = pop_cnt;
        bus.m_rdy = 1'b1;
        @(negedge clk);
        check("t5_error", int'(error), 1);
        check("t5_code", int'(err_code), 3);
        check("t5_busy", int'(busy), 0);
        check("t5_flush", int'(bus.fifo_flush), 1);
        tick(1);
        do_start(2);
        @(negedge clk);
        check("t5_start_ign", int'(busy), 0);
        check("t5_code_hold", int'(err_code), 3);
        tick(2);
        check("t5_no_pop", pop_cnt - p0, 0);
        check("t5_one_flush", flush_cnt - f0, 1);
        abort = 1'b1; tick(1); abort = 1'b0;
        @(negedge clk);
        check("t5_abort_idle", int'(busy), 0);
        check("t5_err_after", int'(error), 1);

        // start+abort together, abort mid-capture, reset mid-drain
        f0 = flush_cnt; d0 = done_cnt;
        start = 1'b1; abort = 1'b1; num_samples = 4;
        tick(1);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("t6_sa_idle", int'(busy), 0);
        check("t6_sa_noflush", flush_cnt - f0, 0);
        tick(1);
        do_start(4);
        tick(1);
        capture(2, 50);
        abort = 1'b1; tick(1); abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("t6_ab_busy", int'(busy), 0);
        check("t6_ab_flush", int'(bus.fifo_flush), 1);
        tick(2);
        check("t6_ab_flushes", flush_cnt - f0, 2);
        check("t6_ab_nodone", done_cnt - d0, 0);
        bus.m_rdy = 1'b0;
        do_start(2);
        tick(1);
        capture(2, 60);
        rstn = 1'b0;
        tick(1);
        exp_q.delete();
        @(negedge clk);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_flags", int'({bus.fifo_wr_vld, bus.fifo_pop, bus.fifo_flush, bus.m_vld, done, error}), 0);
        check("t6_rst_counts", int'({cap_cnt, drn_cnt, err_code}), 0);
        rstn = 1'b1;
        tick(2);
        check("t6_rst_nodone", done_cnt - d0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
